// File: rtl/payload_byte_feeder.sv
// Serialises a 64-bit payload word stream into one byte per cycle for the engine array.
// Drives a one-hot char bus, a per-byte enable, and sod/eod packet framing pulses.
module payload_byte_feeder #(
    parameter  int DATA_WIDTH = 64,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [7:0]            char,
    output logic [255:0]          char_hot,
    output logic                  en,
    output logic                  sod,
    output logic                  eod
);
    localparam int IDX_W = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SOD, BYTES, EOD} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0] mask_q, mask_d;
    logic                  last_q, last_d;
    logic [7:0]            char_q, char_d;
    logic                  en_q, en_d, sod_q, sod_d, eod_q, eod_d, tready_q, tready_d;

    logic                  xfer, emit;
    logic [DATA_WIDTH-1:0] src_data;
    logic [KEEP_WIDTH-1:0] src_mask;
    logic [IDX_W-1:0]      lane;

    function automatic logic [IDX_W-1:0] low_lane(input logic [KEEP_WIDTH-1:0] m);
        low_lane = '0;
        for (int i = KEEP_WIDTH - 1; i >= 0; i--)
            if (m[i]) low_lane = IDX_W'(i);
    endfunction

    // Next-cycle outputs are computed here and registered; a byte chosen at an edge
    // may come straight from the word being accepted at that same edge.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        mask_d   = mask_q;
        last_d   = last_q;
        char_d   = char_q;
        en_d     = 1'b0;
        sod_d    = 1'b0;
        eod_d    = 1'b0;
        tready_d = 1'b0;
        emit     = 1'b0;
        src_data = data_q;
        src_mask = mask_q;
        lane     = '0;
        xfer     = s_axis_tvalid && tready_q;

        case (state_q)
            IDLE, EOD: begin
                if (xfer) begin
                    data_d  = s_axis_tdata;
                    mask_d  = s_axis_tkeep;
                    last_d  = s_axis_tlast;
                    state_d = SOD;
                    sod_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                    tready_d = 1'b1;
                end
            end
            SOD: begin
                if (mask_q == '0) begin
                    state_d  = EOD;
                    eod_d    = 1'b1;
                    tready_d = 1'b1;
                end else begin
                    state_d = BYTES;
                    emit    = 1'b1;
                end
            end
            BYTES: begin
                if (mask_q != '0) begin
                    emit = 1'b1;
                end else if (last_q) begin
                    state_d  = EOD;
                    eod_d    = 1'b1;
                    tready_d = 1'b1;
                end else if (xfer) begin
                    data_d = s_axis_tdata;
                    mask_d = s_axis_tkeep;
                    last_d = s_axis_tlast;
                    if (s_axis_tkeep != '0) begin
                        emit     = 1'b1;
                        src_data = s_axis_tdata;
                        src_mask = s_axis_tkeep;
                    end else if (s_axis_tlast) begin
                        state_d  = EOD;
                        eod_d    = 1'b1;
                        tready_d = 1'b1;
                    end else begin
                        tready_d = 1'b1;
                    end
                end else begin
                    tready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            lane     = low_lane(src_mask);
            char_d   = src_data[8*lane +: 8];
            en_d     = 1'b1;
            mask_d   = src_mask & (src_mask - KEEP_WIDTH'(1));
            tready_d = (mask_d == '0) && !last_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            last_q   <= 1'b0;
            char_q   <= '0;
            en_q     <= 1'b0;
            sod_q    <= 1'b0;
            eod_q    <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            last_q   <= last_d;
            char_q   <= char_d;
            en_q     <= en_d;
            sod_q    <= sod_d;
            eod_q    <= eod_d;
            tready_q <= tready_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign char          = char_q;
    assign en            = en_q;
    assign sod           = sod_q;
    assign eod           = eod_q;
    assign char_hot      = en_q ? (256'd1 << char_q) : '0;
endmodule

// File: tb/tb_payload_byte_feeder.sv
// Directed bench for payload_byte_feeder: framing, byte order, back-pressure and reset abort.
module tb_payload_byte_feeder;
    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic [63:0]  tdata = '0;
    logic [7:0]   tkeep = '0;
    logic         tlast = 1'b0;
    logic         tvalid = 1'b0;
    logic         tready;
    logic [7:0]   ch;
    logic [255:0] ch_hot;
    logic         en, sod, eod;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    payload_byte_feeder #(.DATA_WIDTH(64)) dut (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .char(ch), .char_hot(ch_hot), .en(en), .sod(sod), .eod(eod)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [63:0] d, input logic [7:0] k, input logic l, input logic v);
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tvalid = v;
    endtask

    task automatic ctl(input string tag, input logic e_en, input logic e_sod,
                       input logic e_eod, input logic e_rdy);
        chk({tag, ".en"}, en, e_en);
        chk({tag, ".sod"}, sod, e_sod);
        chk({tag, ".eod"}, eod, e_eod);
        chk({tag, ".tready"}, tready, e_rdy);
        if (!e_en) chk({tag, ".hot"}, ch_hot, '0);
    endtask

    task automatic byte_chk(input string tag, input logic [7:0] b, input logic e_rdy);
        logic [255:0] hot;
        hot = 256'd1 << b;
        chk({tag, ".en"}, en, 1'b1);
        chk({tag, ".char"}, ch, b);
        chk({tag, ".hot"}, ch_hot, hot);
        chk({tag, ".sod"}, sod, 1'b0);
        chk({tag, ".eod"}, eod, 1'b0);
        chk({tag, ".tready"}, tready, e_rdy);
    endtask

    initial begin
        logic [7:0] exp_b [4];

        // Reset state
        #2 resetn = 1'b0;
        #1;
        ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.char", ch, 8'h00);
        step();
        step();
        ctl("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        step();
        ctl("idle0", 1'b0, 1'b0, 1'b0, 1'b1);

        // 1: single word "wp-in"
        put(64'h0000_006E_692D_7077, 8'h1F, 1'b1, 1'b1);
        step();
        ctl("t1.sod", 1'b0, 1'b1, 1'b0, 1'b0);
        tvalid = 1'b0;
        step(); byte_chk("t1.b0", 8'h77, 1'b0);
        step(); byte_chk("t1.b1", 8'h70, 1'b0);
        step(); byte_chk("t1.b2", 8'h2D, 1'b0);
        step(); byte_chk("t1.b3", 8'h69, 1'b0);
        step(); byte_chk("t1.b4", 8'h6E, 1'b0);
        step(); ctl("t1.eod", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); ctl("t1.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // 2: two-word packet, tvalid held high, no bubble
        put(64'h0706_0504_0302_0100, 8'hFF, 1'b0, 1'b1);
        step();
        ctl("t2.sod", 1'b0, 1'b1, 1'b0, 1'b0);
        put(64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step();
            byte_chk($sformatf("t2.b%0d", i), 8'(i), i == 7);
            if (i == 8) tvalid = 1'b0;
        end
        step(); ctl("t2.eod", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); ctl("t2.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // 3: tvalid gap between words of one packet
        put(64'h1716_1514_1312_1110, 8'hFF, 1'b0, 1'b1);
        step();
        ctl("t3.sod", 1'b0, 1'b1, 1'b0, 1'b0);
        tvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            byte_chk($sformatf("t3.b%0d", i), 8'(8'h10 + i), i == 7);
        end
        step(); ctl("t3.gap1", 1'b0, 1'b0, 1'b0, 1'b1);
        step(); ctl("t3.gap2", 1'b0, 1'b0, 1'b0, 1'b1);
        step(); ctl("t3.gap3", 1'b0, 1'b0, 1'b0, 1'b1);
        put(64'h1F1E_1D1C_1B1A_1918, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            byte_chk($sformatf("t3.c%0d", i), 8'(8'h18 + i), 1'b0);
            tvalid = 1'b0;
        end
        step(); ctl("t3.eod", 1'b0, 1'b0, 1'b1, 1'b1);

        // 4: next packet offered during eod
        put(64'h0000_0000_00A3_A2A1, 8'h07, 1'b1, 1'b1);
        step();
        ctl("t4.sod", 1'b0, 1'b1, 1'b0, 1'b0);
        tvalid = 1'b0;
        step(); byte_chk("t4.b0", 8'hA1, 1'b0);
        step(); byte_chk("t4.b1", 8'hA2, 1'b0);
        step(); byte_chk("t4.b2", 8'hA3, 1'b0);
        step(); ctl("t4.eod", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); ctl("t4.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // 5: sparse tkeep, then zero-length packet
        exp_b = '{8'h30, 8'h32, 8'h35, 8'h37};
        put(64'h3736_3534_3332_3130, 8'hA5, 1'b1, 1'b1);
        step();
        ctl("t5.sod", 1'b0, 1'b1, 1'b0, 1'b0);
        tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            byte_chk($sformatf("t5.b%0d", i), exp_b[i], 1'b0);
        end
        step(); ctl("t5.eod", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); ctl("t5.idle", 1'b0, 1'b0, 1'b0, 1'b1);
        put(64'hDEAD_BEEF_0000_0000, 8'h00, 1'b1, 1'b1);
        step();
        ctl("t5z.sod", 1'b0, 1'b1, 1'b0, 1'b0);
        tvalid = 1'b0;
        step(); ctl("t5z.eod", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); ctl("t5z.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // 6: asynchronous reset mid-packet
        put(64'h5756_5554_5352_5150, 8'hFF, 1'b1, 1'b1);
        step();
        ctl("t6.sod", 1'b0, 1'b1, 1'b0, 1'b0);
        tvalid = 1'b0;
        step(); byte_chk("t6.b0", 8'h50, 1'b0);
        step(); byte_chk("t6.b1", 8'h51, 1'b0);
        step(); byte_chk("t6.b2", 8'h52, 1'b0);
        #2 resetn = 1'b0;
        #1;
        ctl("t6.arst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6.arst.char", ch, 8'h00);
        step();
        ctl("t6.rst_edge", 1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        step(); ctl("t6.post1", 1'b0, 1'b0, 1'b0, 1'b1);
        step(); ctl("t6.post2", 1'b0, 1'b0, 1'b0, 1'b1);
        put(64'h0000_0000_0000_6261, 8'h03, 1'b1, 1'b1);
        step();
        ctl("t6.sod2", 1'b0, 1'b1, 1'b0, 1'b0);
        tvalid = 1'b0;
        step(); byte_chk("t6.n0", 8'h61, 1'b0);
        step(); byte_chk("t6.n1", 8'h62, 1'b0);
        step(); ctl("t6.eod", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); ctl("t6.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
